// File: rtl/wave_pkg.sv
// wave_pkg: shared definitions for the multi-channel wave bank.
//   - per-channel register offsets inside an 8-byte channel window
//   - CHANNEL_STRIDE (bytes per channel window)
//   - ID register high nibble and wavetype encodings
//   - id_byte(): builds the read value of the ID register
package wave_pkg;

  localparam int CHANNEL_STRIDE = 8;

  localparam logic [2:0] REG_INCR_LO    = 3'd0;
  localparam logic [2:0] REG_INCR_HI    = 3'd1;
  localparam logic [2:0] REG_WAVETYPE   = 3'd2;
  localparam logic [2:0] REG_PULSEWIDTH = 3'd3;
  localparam logic [2:0] REG_GATE       = 3'd4;

  localparam logic [3:0] ID_NIBBLE = 4'hA;

  typedef enum logic [1:0] {
    WAVE_SAW      = 2'd0,
    WAVE_PULSE    = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_NOISE    = 2'd3
  } wavetype_e;

  // ID register: fixed nibble over (channel count - 1)
  function automatic logic [7:0] id_byte(input int num_channels);
    logic [3:0] count_s;
    count_s = 4'(num_channels - 1);
    return {ID_NIBBLE, count_s};
  endfunction

endpackage

// File: rtl/wave_bank_controller_channel_regs.sv
// wave_channel_regs: register set of one voice plus its WaveGen.
//   Clock, Reset (async active-low)
//   wr_en    : write strobe already decoded for this channel
//   reg_sel  : register offset within the channel window
//   wdata    : bus write byte
//   rdata    : combinational read byte for reg_sel (registered by the top)
//   Waveform : this voice's sample
module wave_channel_regs
  import wave_pkg::*;
#(
  parameter int WAVE_DEPTH = 8,
  parameter int INCR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  wr_en,
  input  logic [2:0]            reg_sel,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic [WAVE_DEPTH-1:0] Waveform
);

  logic [7:0]            shadow_r;
  logic [INCR_WIDTH-1:0] incr_r;
  wavetype_e             wavetype_r;
  logic [WAVE_DEPTH-1:0] pulsewidth_r;
  logic                  gate_r;
  logic                  gate_open_r;
  logic                  gate_close_r;
  logic [15:0]           incr_full_s;
  logic [15:0]           incr_ext_s;

  // Low byte comes from the shadow so both bytes land in one edge
  assign incr_full_s = {wdata, shadow_r};
  assign incr_ext_s  = 16'(incr_r);

  // Register writes; gate pulses last only the cycle after the write
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shadow_r     <= 8'h00;
      incr_r       <= '0;
      wavetype_r   <= WAVE_SAW;
      pulsewidth_r <= '0;
      gate_r       <= 1'b0;
      gate_open_r  <= 1'b0;
      gate_close_r <= 1'b0;
    end else begin
      gate_open_r  <= 1'b0;
      gate_close_r <= 1'b0;
      if (wr_en) begin
        case (reg_sel)
          REG_INCR_LO:    shadow_r     <= wdata;
          REG_INCR_HI:    incr_r       <= incr_full_s[INCR_WIDTH-1:0];
          REG_WAVETYPE:   wavetype_r   <= wavetype_e'(wdata[1:0]);
          REG_PULSEWIDTH: pulsewidth_r <= wdata[WAVE_DEPTH-1:0];
          REG_GATE: begin
            gate_r       <= wdata[0];
            gate_open_r  <= wdata[0];
            gate_close_r <= ~wdata[0];
          end
          default: ;
        endcase
      end
    end
  end

  // Read-data selection; reserved offsets read zero
  always_comb begin
    rdata = 8'h00;
    case (reg_sel)
      REG_INCR_LO:    rdata = incr_ext_s[7:0];
      REG_INCR_HI:    rdata = incr_ext_s[15:8];
      REG_WAVETYPE:   rdata = {6'b000000, wavetype_r};
      REG_PULSEWIDTH: rdata = 8'(pulsewidth_r);
      REG_GATE:       rdata = {7'b0000000, gate_r};
      default:        rdata = 8'h00;
    endcase
  end

  WaveGen #(
    .WAVE_DEPTH(WAVE_DEPTH),
    .INCR_WIDTH(INCR_WIDTH)
  ) u_wavegen (
    .Clock     (Clock),
    .Reset     (Reset),
    .incr      (incr_r),
    .wavetype  (wavetype_r),
    .pulsewidth(pulsewidth_r),
    .GateOpen  (gate_open_r),
    .GateClose (gate_close_r),
    .Waveform  (Waveform)
  );

endmodule

// File: rtl/wave_gen.sv
// WaveGen: single voice oscillator.
//   Clock, Reset (async active-low)
//   incr       : phase increment added every cycle while the gate is open
//   wavetype   : saw / pulse / triangle / noise
//   pulsewidth : pulse threshold against the top phase bits
//   GateOpen / GateClose : one-cycle pulses opening/closing the gate
//   Waveform   : registered sample; held at zero while the gate is closed
module WaveGen
  import wave_pkg::*;
#(
  parameter int WAVE_DEPTH = 8,
  parameter int INCR_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [INCR_WIDTH-1:0] incr,
  input  wavetype_e             wavetype,
  input  logic [WAVE_DEPTH-1:0] pulsewidth,
  input  logic                  GateOpen,
  input  logic                  GateClose,
  output logic [WAVE_DEPTH-1:0] Waveform
);

  logic                  gate_r;
  logic [INCR_WIDTH-1:0] phase_r;
  logic [15:0]           lfsr_r;
  logic [WAVE_DEPTH-1:0] wave_r;
  logic [WAVE_DEPTH-1:0] phase_top_s;
  logic [WAVE_DEPTH-1:0] tri_s;
  logic [WAVE_DEPTH-1:0] sample_s;

  assign phase_top_s = phase_r[INCR_WIDTH-1 -: WAVE_DEPTH];
  // Triangle folds the phase below the MSB, doubling slope
  assign tri_s       = phase_r[INCR_WIDTH-2 -: WAVE_DEPTH];
  assign Waveform    = wave_r;

  // Sample shaping from the current phase
  always_comb begin
    sample_s = '0;
    case (wavetype)
      WAVE_SAW: sample_s = phase_top_s;
      WAVE_PULSE: begin
        if (phase_top_s < pulsewidth) begin
          sample_s = '1;
        end else begin
          sample_s = '0;
        end
      end
      WAVE_TRIANGLE: begin
        if (phase_r[INCR_WIDTH-1]) begin
          sample_s = ~tri_s;
        end else begin
          sample_s = tri_s;
        end
      end
      WAVE_NOISE: sample_s = lfsr_r[WAVE_DEPTH-1:0];
      default:    sample_s = '0;
    endcase
  end

  // Gate state, phase accumulator, noise LFSR and output register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      gate_r  <= 1'b0;
      phase_r <= '0;
      lfsr_r  <= 16'hACE1;
      wave_r  <= '0;
    end else begin
      if (GateOpen) begin
        gate_r <= 1'b1;
      end else if (GateClose) begin
        gate_r <= 1'b0;
      end else begin
        gate_r <= gate_r;
      end
      if (gate_r) begin
        phase_r <= phase_r + incr;
        lfsr_r  <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        wave_r  <= sample_s;
      end else begin
        phase_r <= '0;
        lfsr_r  <= lfsr_r;
        wave_r  <= '0;
      end
    end
  end

endmodule

// File: rtl/wave_bank_controller.sv
// wave_bank_controller: NUM_CHANNELS WaveGen voices behind a byte bus.
//   Clock, Reset (async active-low)
//   BusAddress/BusDataIn/BusValid/BusReadWrite : one access per cycle
//   BusDataOut/BusReadValid : registered read response, one cycle later
//   Waveform : channel c at [c*WAVE_DEPTH +: WAVE_DEPTH]
module wave_bank_controller
  import wave_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          WAVE_DEPTH   = 8,
  parameter int          INCR_WIDTH   = 16,
  parameter logic [15:0] ADDR         = 16'h0000
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic [15:0]                        BusAddress,
  input  logic [7:0]                         BusDataIn,
  output logic [7:0]                         BusDataOut,
  input  logic                               BusValid,
  input  logic                               BusReadWrite,
  output logic                               BusReadValid,
  output logic [NUM_CHANNELS*WAVE_DEPTH-1:0] Waveform
);

  localparam int WINDOW_BYTES = CHANNEL_STRIDE * NUM_CHANNELS;

  logic [15:0]             offset_s;
  logic                    in_window_s;
  logic                    is_id_s;
  logic [3:0]              chan_s;
  logic [2:0]              reg_s;
  logic                    wr_s;
  logic                    rd_s;
  logic [NUM_CHANNELS-1:0] chan_wr_s;
  logic [7:0]              chan_rdata_s [NUM_CHANNELS];
  logic [7:0]              rd_next_s;
  logic [7:0]              rd_data_r;
  logic                    rd_valid_r;

  // Addresses below ADDR wrap to large offsets and fall outside every window
  assign offset_s    = BusAddress - ADDR;
  assign in_window_s = (offset_s < 16'(WINDOW_BYTES));
  assign is_id_s     = (offset_s == 16'(WINDOW_BYTES));
  assign chan_s      = offset_s[6:3];
  assign reg_s       = offset_s[2:0];
  assign wr_s        = BusValid & BusReadWrite;
  assign rd_s        = BusValid & ~BusReadWrite;

  assign BusDataOut   = rd_data_r;
  assign BusReadValid = rd_valid_r;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign chan_wr_s[c] = wr_s & in_window_s & (chan_s == 4'(c));

    wave_channel_regs #(
      .WAVE_DEPTH(WAVE_DEPTH),
      .INCR_WIDTH(INCR_WIDTH)
    ) u_chan (
      .Clock   (Clock),
      .Reset   (Reset),
      .wr_en   (chan_wr_s[c]),
      .reg_sel (reg_s),
      .wdata   (BusDataIn),
      .rdata   (chan_rdata_s[c]),
      .Waveform(Waveform[c*WAVE_DEPTH +: WAVE_DEPTH])
    );
  end

  // Read mux: channel register, ID, or zero for unmapped addresses
  always_comb begin
    rd_next_s = 8'h00;
    if (in_window_s) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (chan_s == 4'(c)) begin
          rd_next_s = chan_rdata_s[c];
        end else begin
          rd_next_s = rd_next_s;
        end
      end
    end else if (is_id_s) begin
      rd_next_s = id_byte(NUM_CHANNELS);
    end else begin
      rd_next_s = 8'h00;
    end
  end

  // Read response register; data forced to zero outside the valid cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 8'h00;
    end else begin
      rd_valid_r <= rd_s;
      if (rd_s) begin
        rd_data_r <= rd_next_s;
      end else begin
        rd_data_r <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_wave_bank_controller.sv
module tb_wave_bank_controller;

  localparam int          NCH  = 4;
  localparam int          WD   = 6;
  localparam int          IW   = 16;
  localparam logic [15:0] BASE = 16'h0100;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic [15:0]       BusAddress = 16'h0000;
  logic [7:0]        BusDataIn = 8'h00;
  logic [7:0]        BusDataOut;
  logic              BusValid = 1'b0;
  logic              BusReadWrite = 1'b0;
  logic              BusReadValid;
  logic [NCH*WD-1:0] Waveform;

  int checks = 0;
  int failures = 0;

  // Reference register file, kept as plain integers
  int m_incr   [NCH];
  int m_shadow [NCH];
  int m_wtype  [NCH];
  int m_pw     [NCH];
  int m_gate   [NCH];

  wave_bank_controller #(
    .NUM_CHANNELS(NCH),
    .WAVE_DEPTH  (WD),
    .INCR_WIDTH  (IW),
    .ADDR        (BASE)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BusAddress  (BusAddress),
    .BusDataIn   (BusDataIn),
    .BusDataOut  (BusDataOut),
    .BusValid    (BusValid),
    .BusReadWrite(BusReadWrite),
    .BusReadValid(BusReadValid),
    .Waveform    (Waveform)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_incr[c] = 0; m_shadow[c] = 0; m_wtype[c] = 0; m_pw[c] = 0; m_gate[c] = 0;
    end
  endfunction

  function automatic int model_read(input int addr);
    int off;
    int c;
    off = addr - int'(BASE);
    if (off >= 0 && off < 8 * NCH) begin
      c = off / 8;
      case (off % 8)
        0: return m_incr[c] % 256;
        1: return (m_incr[c] / 256) % 256;
        2: return m_wtype[c];
        3: return m_pw[c];
        4: return m_gate[c];
        default: return 0;
      endcase
    end
    if (off == 8 * NCH) return 160 + NCH - 1;
    return 0;
  endfunction

  function automatic void model_write(input int addr, input int data);
    int off;
    int c;
    off = addr - int'(BASE);
    if (off >= 0 && off < 8 * NCH) begin
      c = off / 8;
      case (off % 8)
        0: m_shadow[c] = data;
        1: m_incr[c] = (data * 256 + m_shadow[c]) % (1 << IW);
        2: m_wtype[c] = data % 4;
        3: m_pw[c] = data % (1 << WD);
        4: m_gate[c] = data % 2;
        default: ;
      endcase
    end
  endfunction

  // One bus cycle; returns #1 after the accepting edge
  task automatic access(input logic rw, input int addr, input int data);
    BusValid     = 1'b1;
    BusReadWrite = rw;
    BusAddress   = addr[15:0];
    BusDataIn    = data[7:0];
    @(posedge Clock);
    #1;
    BusValid     = 1'b0;
    BusReadWrite = 1'b0;
    if (rw) model_write(addr, data);
  endtask

  task automatic test_reset();
    int exp;
    Reset = 1'b0;
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if (BusReadValid !== 1'b0 || BusDataOut !== 8'h00) begin
      failures++;
      $display("FAIL reset_bus: valid=%0b data=%02h required valid=0 data=00", BusReadValid, BusDataOut);
    end
    checks++;
    if (Waveform !== '0) begin
      failures++;
      $display("FAIL reset_wave: got %h required 0", Waveform);
    end
    Reset = 1'b1;
    for (int r = 0; r <= 8 * NCH; r++) begin
      if (r < 8 || r == 8 * NCH) begin
        exp = (r == 8 * NCH) ? 8'hA3 : 8'h00;
        access(1'b0, int'(BASE) + r, 0);
        checks++;
        if (BusReadValid !== 1'b1 || BusDataOut !== exp[7:0]) begin
          failures++;
          $display("FAIL reset_read off=%0d: valid=%0b data=%02h required valid=1 data=%02h", r, BusReadValid, BusDataOut, exp[7:0]);
        end
      end
    end
    @(posedge Clock);
    #1;
    checks++;
    if (BusReadValid !== 1'b0 || BusDataOut !== 8'h00) begin
      failures++;
      $display("FAIL read_idle: valid=%0b data=%02h required valid=0 data=00", BusReadValid, BusDataOut);
    end
  endtask

  task automatic test_incr_atomic();
    int a;
    int exp;
    a = int'(BASE) + 16;
    access(1'b1, a, 8'h34);
    access(1'b0, a, 0);
    checks++;
    if (BusDataOut !== 8'h00) begin
      failures++;
      $display("FAIL incr_lo_only: got %02h required 00", BusDataOut);
    end
    access(1'b1, a + 1, 8'h12);
    access(1'b0, a, 0);
    checks++;
    if (BusReadValid !== 1'b1 || BusDataOut !== 8'h34) begin
      failures++;
      $display("FAIL incr_commit_lo: got %02h required 34", BusDataOut);
    end
    access(1'b0, a + 1, 0);
    checks++;
    if (BusDataOut !== 8'h12) begin
      failures++;
      $display("FAIL incr_commit_hi: got %02h required 12", BusDataOut);
    end
    for (int c = 0; c < NCH; c++) begin
      if (c != 2) begin
        for (int b = 0; b < 2; b++) begin
          exp = model_read(int'(BASE) + 8 * c + b);
          access(1'b0, int'(BASE) + 8 * c + b, 0);
          checks++;
          if (BusDataOut !== exp[7:0]) begin
            failures++;
            $display("FAIL incr_other ch=%0d b=%0d: got %02h required %02h", c, b, BusDataOut, exp[7:0]);
          end
        end
      end
    end
  endtask

  task automatic test_gate();
    int a;
    a = int'(BASE) + 8 + 4;
    BusValid = 1'b1; BusReadWrite = 1'b1; BusAddress = a[15:0]; BusDataIn = 8'h01;
    @(posedge Clock);
    #1;
    model_write(a, 1);
    checks++;
    if (dut.g_chan[1].u_chan.gate_open_r !== 1'b1 || dut.g_chan[1].u_chan.gate_close_r !== 1'b0) begin
      failures++;
      $display("FAIL gate_open_pulse: open=%0b close=%0b required open=1 close=0",
               dut.g_chan[1].u_chan.gate_open_r, dut.g_chan[1].u_chan.gate_close_r);
    end
    BusDataIn = 8'h00;
    @(posedge Clock);
    #1;
    model_write(a, 0);
    BusValid = 1'b0; BusReadWrite = 1'b0;
    checks++;
    if (dut.g_chan[1].u_chan.gate_open_r !== 1'b0 || dut.g_chan[1].u_chan.gate_close_r !== 1'b1) begin
      failures++;
      $display("FAIL gate_close_pulse: open=%0b close=%0b required open=0 close=1",
               dut.g_chan[1].u_chan.gate_open_r, dut.g_chan[1].u_chan.gate_close_r);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (dut.g_chan[1].u_chan.gate_open_r !== 1'b0 || dut.g_chan[1].u_chan.gate_close_r !== 1'b0) begin
      failures++;
      $display("FAIL gate_pulse_end: open=%0b close=%0b required both 0",
               dut.g_chan[1].u_chan.gate_open_r, dut.g_chan[1].u_chan.gate_close_r);
    end
    access(1'b0, a, 0);
    checks++;
    if (BusReadValid !== 1'b1 || BusDataOut !== 8'h00) begin
      failures++;
      $display("FAIL gate_read: got %02h required 00", BusDataOut);
    end
  endtask

  task automatic test_widths();
    access(1'b1, int'(BASE) + 3, 8'hFF);
    access(1'b0, int'(BASE) + 3, 0);
    checks++;
    if (BusDataOut !== 8'h3F) begin
      failures++;
      $display("FAIL pulsewidth_trunc: got %02h required 3F", BusDataOut);
    end
    access(1'b1, int'(BASE) + 2, 8'hFE);
    access(1'b0, int'(BASE) + 2, 0);
    checks++;
    if (BusDataOut !== 8'h02) begin
      failures++;
      $display("FAIL wavetype_trunc: got %02h required 02", BusDataOut);
    end
  endtask

  task automatic test_out_of_window();
    int exp;
    int addrs [4];
    addrs[0] = int'(BASE) + 8'h40;
    addrs[1] = int'(BASE) + 5;
    addrs[2] = int'(BASE) + 8 * NCH;
    addrs[3] = 0;
    for (int i = 0; i < 4; i++) access(1'b1, addrs[i], 8'h5A);
    for (int i = 0; i < 4; i++) begin
      exp = model_read(addrs[i]);
      access(1'b0, addrs[i], 0);
      checks++;
      if (BusReadValid !== 1'b1 || BusDataOut !== exp[7:0]) begin
        failures++;
        $display("FAIL unmapped_read addr=%04h: valid=%0b data=%02h required valid=1 data=%02h",
                 addrs[i][15:0], BusReadValid, BusDataOut, exp[7:0]);
      end
    end
    for (int off = 0; off < 8 * NCH; off++) begin
      exp = model_read(int'(BASE) + off);
      access(1'b0, int'(BASE) + off, 0);
      checks++;
      if (BusDataOut !== exp[7:0]) begin
        failures++;
        $display("FAIL unmapped_side_effect off=%0d: got %02h required %02h", off, BusDataOut, exp[7:0]);
      end
    end
  endtask

  task automatic test_reset_shadow();
    int a;
    a = int'(BASE) + 24;
    access(1'b1, a, 8'hAA);
    access(1'b0, int'(BASE) + 8 * NCH, 0);
    #3;
    Reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (BusReadValid !== 1'b0 || BusDataOut !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: valid=%0b data=%02h required valid=0 data=00", BusReadValid, BusDataOut);
    end
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    access(1'b1, a + 1, 8'h01);
    access(1'b0, a, 0);
    checks++;
    if (BusDataOut !== 8'h00) begin
      failures++;
      $display("FAIL shadow_cleared_lo: got %02h required 00", BusDataOut);
    end
    access(1'b0, a + 1, 0);
    checks++;
    if (BusDataOut !== 8'h01) begin
      failures++;
      $display("FAIL shadow_cleared_hi: got %02h required 01", BusDataOut);
    end
  endtask

  task automatic test_random();
    int   addr;
    int   data;
    int   exp;
    logic rw;
    for (int i = 0; i < 400; i++) begin
      rw   = 1'($urandom_range(0, 1));
      addr = int'(BASE) - 4 + int'($urandom_range(0, 16'h4C));
      data = int'($urandom_range(0, 255));
      exp  = rw ? 0 : model_read(addr);
      access(rw, addr, data);
      checks++;
      if (BusReadValid !== !rw || BusDataOut !== exp[7:0]) begin
        failures++;
        $display("FAIL random i=%0d rw=%0b addr=%04h: valid=%0b data=%02h required valid=%0b data=%02h",
                 i, rw, addr[15:0], BusReadValid, BusDataOut, !rw, exp[7:0]);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge Clock);
        #1;
        checks++;
        if (BusReadValid !== 1'b0 || BusDataOut !== 8'h00) begin
          failures++;
          $display("FAIL random_idle i=%0d: valid=%0b data=%02h required valid=0 data=00", i, BusReadValid, BusDataOut);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_incr_atomic();
    test_gate();
    test_widths();
    test_out_of_window();
    test_reset_shadow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
